multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle FSM controller that sequences the shared MIPS datapath (single ALU, unified memory port, register file) one instruction at a time.
- Decodes OpCode/Funct from the latched instruction register and issues per-state control strobes.
- Handles a memory ready handshake, with a timeout that halts the core.
- Replaces the single-cycle combinational controller in the next core revision.

Parameters:
- MEM_TIMEOUT, 16, max consecutive cycles waiting for mem_ready before halt (legal range 1..255).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- OpCode  in  6  instr[31:26] from IR.
- Funct  in  6  instr[5:0] from IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCEn  out  1  PC load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  IR load.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegDest  out  2  write register select: 00 = rt, 01 = rd, 10 = $31.
- MemtoReg  out  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm << 2.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui (B << 16).
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend.
- PCSource  out  2  PC next select: 00 = ALU result, 01 = ALUOut, 10 = jump concat, 11 = rs.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported instruction.
- halted  out  1  high while in HALT.
- state  out  4  current state, for debug.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, RWB 7, EXEC_I 8, IWB 9, BRANCH 10, JUMP 11, HALT 15.
- Outputs are a Moore decode of state, except PCEn/IRWrite (gated by mem_ready or Zero).
- Every output not listed for a state is 0.
- Reset (reset == 0 at a rising edge):
  - state <= FETCH, wait counter <= 0.
  - While reset is low, all outputs are forced to 0 and state reads 0.
  - Reset mid-instruction aborts the instruction; nothing further is written.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=PCEn=mem_ready.
  - Advance to DECODE only when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=000, ExtOp=1 (branch target into ALUOut).
  - Next state: addu/subu → EXEC_R; ori/lui → EXEC_I; lw/sw → MEMADR; beq → BRANCH; j/jal/jr → JUMP.
  - Any other op → illegal=1 for one cycle, then FETCH (executes as nop).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=000. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDest=00, MemtoReg=01, instr_done=1, then FETCH.
- MEMWR: MemWrite=1, IorD=1. On mem_ready: instr_done=1, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=000 for addu, 001 for subu. Next RWB.
- RWB: RegWrite=1, RegDest=01, MemtoReg=00, instr_done=1, then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUOp=010 for ori, 011 for lui. Next IWB.
- IWB: RegWrite=1, RegDest=00, MemtoReg=00, instr_done=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCEn=Zero, instr_done=1, then FETCH.
- JUMP: PCEn=1, instr_done=1, then FETCH.
  - PCSource=11 for jr, 10 otherwise.
  - jal also drives RegWrite=1, RegDest=10, MemtoReg=10 (PC already +4).
- Latency with mem_ready tied high:
  - beq/j/jal/jr: 3 cycles.
  - addu/subu/ori/lui/sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Increments on each cycle in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: go to HALT.
  - mem_ready=1 in the same cycle the count hits the limit counts as success.
- HALT: all strobes 0, halted=1. Only reset leaves HALT.
- Opcodes/functs decoded:
  - addu 000000/100001, subu 000000/100011, jr 000000/001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.

Test Plan:
- Hold reset=0 for 2 cycles with mem_ready=1 → all outputs 0, state=0. Release → FETCH has MemRead=1, IRWrite=1, PCEn=1.
- addu (Funct 100001) then lw, mem_ready=1 → state sequences 0,1,6,7 then 0,1,2,3,4.
  - instr_done pulses at state 7 and state 4.
  - RWB has RegDest=01; MEMWB has MemtoReg=01.
- beq with Zero=1 then Zero=0 → BRANCH has PCEn=1 then 0, PCSource=01.
  - jal → JUMP has PCEn=1, PCSource=10, RegWrite=1, RegDest=10, MemtoReg=10.
- sw with mem_ready low for 3 cycles in MEMWR → MemWrite held 4 cycles, instr_done only on the ready cycle, total 7 cycles.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → HALT after 4 wait cycles, halted=1, all strobes 0.
  - Then reset=0 for 1 cycle → FETCH.
- OpCode 111111 → illegal pulses in DECODE, no RegWrite/MemWrite/PCEn, next state FETCH. Assert reset=0 during MEMRD → next cycle state=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle FSM controller for the shared MIPS datapath. Walks
//             one instruction at a time through FETCH/DECODE/execute/writeback
//             states, waits on the memory ready handshake and halts the core
//             if memory fails to answer within MEM_TIMEOUT cycles.
//  Ports    : clk, reset (sync, active-low)
//             OpCode/Funct  - instruction fields from the IR
//             Zero          - ALU zero flag (beq decision)
//             mem_ready     - memory completes the current access this cycle
//             PCEn..PCSource - datapath control strobes
//             instr_done    - pulse in the last state of an instruction
//             illegal       - pulse when DECODE sees an unsupported op
//             halted        - high while in HALT
//             state         - current state (debug)
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCEn,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] RegDest,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    // Last count value before timing out: the MEM_TIMEOUT-th idle cycle halts.
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;

    logic w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_mem_wait_state;

    assign w_addu = (OpCode == c_OP_RTYPE) && (Funct == c_FN_ADDU);
    assign w_subu = (OpCode == c_OP_RTYPE) && (Funct == c_FN_SUBU);
    assign w_jr   = (OpCode == c_OP_RTYPE) && (Funct == c_FN_JR);
    assign w_ori  = (OpCode == c_OP_ORI);
    assign w_lui  = (OpCode == c_OP_LUI);
    assign w_lw   = (OpCode == c_OP_LW);
    assign w_sw   = (OpCode == c_OP_SW);
    assign w_beq  = (OpCode == c_OP_BEQ);
    assign w_j    = (OpCode == c_OP_J);
    assign w_jal  = (OpCode == c_OP_JAL);

    assign w_mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                              (state_q == S_MEMWR);

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        wait_d  = 8'd0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (w_addu || w_subu)          state_d = S_EXEC_R;
                else if (w_ori || w_lui)       state_d = S_EXEC_I;
                else if (w_lw || w_sw)         state_d = S_MEMADR;
                else if (w_beq)                state_d = S_BRANCH;
                else if (w_j || w_jal || w_jr) state_d = S_JUMP;
                else                           state_d = S_FETCH;
            end
            S_MEMADR: begin
                if (w_lw)      state_d = S_MEMRD;
                else if (w_sw) state_d = S_MEMWR;
                else           state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWR:  state_d = S_FETCH;
            S_EXEC_R: state_d = S_RWB;
            S_EXEC_I: state_d = S_IWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase

        // Memory states hold until ready; ready on the limit cycle still wins.
        if (w_mem_wait_state && !mem_ready) begin
            if (wait_q == c_WAIT_LAST) begin
                state_d = S_HALT;
            end else begin
                state_d = state_q;
                wait_d  = wait_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Moore decode of the state register; everything is forced low in reset.
    always_comb begin
        PCEn       = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegDest    = 2'b00;
        MemtoReg   = 2'b00;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 3'b000;
        ExtOp      = 1'b0;
        PCSource   = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCEn    = mem_ready;
                end
                S_DECODE: begin
                    // Precompute the branch target into ALUOut.
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    illegal = !(w_addu || w_subu || w_ori || w_lui || w_lw ||
                                w_sw || w_beq || w_j || w_jal || w_jr);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b01;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = w_subu ? 3'b001 : 3'b000;
                end
                S_RWB: begin
                    RegWrite   = 1'b1;
                    RegDest    = 2'b01;
                    instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = w_lui ? 3'b011 : 3'b010;
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = 3'b001;
                    PCSource   = 2'b01;
                    PCEn       = Zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCEn       = 1'b1;
                    PCSource   = w_jr ? 2'b11 : 2'b10;
                    instr_done = 1'b1;
                    if (w_jal) begin
                        // Link address is the already-incremented PC.
                        RegWrite = 1'b1;
                        RegDest  = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = reset ? state_q : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl. A table of per-cycle
//             {inputs, expected state, expected strobes} records is applied
//             in order, followed by hand-written latency sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       Zero, mem_ready;
    logic       PCEn, IorD, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA, ExtOp;
    logic [1:0] RegDest, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       instr_done, illegal, halted;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCEn(PCEn), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegDest(RegDest),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal(illegal), .halted(halted), .state(state)
    );

    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUBU = 6'b100011, FN_JR = 6'b001000;

    // Strobe vector field order:
    // PCEn,IorD,IRWrite,MemRead,MemWrite,RegDest,MemtoReg,RegWrite,ALUSrcA,
    // ALUSrcB,ALUOp,ExtOp,PCSource,instr_done,illegal,halted
    localparam logic [21:0] E_ZERO    = 22'd0;
    localparam logic [21:0] E_FETCH_R = {1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,3'b000,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_FETCH_W = {1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,3'b000,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_DEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,3'b000,1'b1,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,3'b000,1'b1,2'b00,1'b0,1'b1,1'b0};
    localparam logic [21:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,3'b000,1'b1,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_MEMRD   = {1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,2'b00,3'b000,1'b0,2'b00,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_MEMWR_W = {1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_MEMWR_R = {1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_EX_ADD  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,3'b000,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_EX_SUB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,3'b001,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_RWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,1'b0,2'b00,3'b000,1'b0,2'b00,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_EX_ORI  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,3'b010,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_EX_LUI  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,3'b011,1'b0,2'b00,1'b0,1'b0,1'b0};
    localparam logic [21:0] E_IWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,2'b00,3'b000,1'b0,2'b00,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_BR_Z1   = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,3'b001,1'b0,2'b01,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_BR_Z0   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,3'b001,1'b0,2'b01,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_JAL     = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,2'b10,1'b1,1'b0,2'b00,3'b000,1'b0,2'b10,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_J       = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b10,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_JR      = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b11,1'b1,1'b0,1'b0};
    localparam logic [21:0] E_HALT    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,3'b000,1'b0,2'b00,1'b0,1'b0,1'b1};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [21:0] ctl;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic rdy, input logic [3:0] st,
                                input logic [21:0] ctl);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl;
        tbl.push_back(v);
    endfunction

    function automatic logic [21:0] observed();
        return {PCEn, IorD, IRWrite, MemRead, MemWrite, RegDest, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource, instr_done, illegal, halted};
    endfunction

    // Runs one instruction from a fresh FETCH with mem_ready high except for
    // nwait stall cycles in MEMWR; counts cycles up to and including instr_done.
    task automatic run_latency(input string name, input logic [5:0] op, input logic [5:0] fn,
                               input int nwait, input int exp_cycles);
        int  n;
        int  left;
        bit  done;
        reset = 1'b0; mem_ready = 1'b1; Zero = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; OpCode = op; Funct = fn;
        left = nwait; n = 0; done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            if (state == 4'd5 && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            n++;
            if (instr_done) done = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (!done || n != exp_cycles) begin
            failures++;
            $display("FAIL latency_%s: got %0d cycles (done=%0b), want %0d", name, n, done, exp_cycles);
        end
    endtask

    initial begin
        // rst, op, fn, Zero, mem_ready, expected state, expected strobes
        add(0, OP_R,   FN_ADDU, 0, 1, 4'd0,  E_ZERO);
        add(0, OP_R,   FN_ADDU, 0, 1, 4'd0,  E_ZERO);
        // addu
        add(1, OP_R,   FN_ADDU, 0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_R,   FN_ADDU, 0, 1, 4'd1,  E_DEC);
        add(1, OP_R,   FN_ADDU, 0, 1, 4'd6,  E_EX_ADD);
        add(1, OP_R,   FN_ADDU, 0, 1, 4'd7,  E_RWB);
        // lw
        add(1, OP_LW,  6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_LW,  6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_LW,  6'd0,    0, 1, 4'd2,  E_MEMADR);
        add(1, OP_LW,  6'd0,    0, 1, 4'd3,  E_MEMRD);
        add(1, OP_LW,  6'd0,    0, 1, 4'd4,  E_MEMWB);
        // subu
        add(1, OP_R,   FN_SUBU, 0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_R,   FN_SUBU, 0, 1, 4'd1,  E_DEC);
        add(1, OP_R,   FN_SUBU, 0, 1, 4'd6,  E_EX_SUB);
        add(1, OP_R,   FN_SUBU, 0, 1, 4'd7,  E_RWB);
        // ori, lui
        add(1, OP_ORI, 6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_ORI, 6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_ORI, 6'd0,    0, 1, 4'd8,  E_EX_ORI);
        add(1, OP_ORI, 6'd0,    0, 1, 4'd9,  E_IWB);
        add(1, OP_LUI, 6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_LUI, 6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_LUI, 6'd0,    0, 1, 4'd8,  E_EX_LUI);
        add(1, OP_LUI, 6'd0,    0, 1, 4'd9,  E_IWB);
        // beq taken, then not taken
        add(1, OP_BEQ, 6'd0,    1, 1, 4'd0,  E_FETCH_R);
        add(1, OP_BEQ, 6'd0,    1, 1, 4'd1,  E_DEC);
        add(1, OP_BEQ, 6'd0,    1, 1, 4'd10, E_BR_Z1);
        add(1, OP_BEQ, 6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_BEQ, 6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_BEQ, 6'd0,    0, 1, 4'd10, E_BR_Z0);
        // jal, j, jr
        add(1, OP_JAL, 6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_JAL, 6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_JAL, 6'd0,    0, 1, 4'd11, E_JAL);
        add(1, OP_J,   6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_J,   6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_J,   6'd0,    0, 1, 4'd11, E_J);
        add(1, OP_R,   FN_JR,   0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_R,   FN_JR,   0, 1, 4'd1,  E_DEC);
        add(1, OP_R,   FN_JR,   0, 1, 4'd11, E_JR);
        // illegal opcode executes as a nop
        add(1, OP_BAD, 6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_BAD, 6'd0,    0, 1, 4'd1,  E_DEC_ILL);
        // sw with three stall cycles in MEMWR
        add(1, OP_SW,  6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_SW,  6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_SW,  6'd0,    0, 1, 4'd2,  E_MEMADR);
        add(1, OP_SW,  6'd0,    0, 0, 4'd5,  E_MEMWR_W);
        add(1, OP_SW,  6'd0,    0, 0, 4'd5,  E_MEMWR_W);
        add(1, OP_SW,  6'd0,    0, 0, 4'd5,  E_MEMWR_W);
        add(1, OP_SW,  6'd0,    0, 1, 4'd5,  E_MEMWR_R);
        // fetch stall, then lw aborted by reset in MEMRD
        add(1, OP_LW,  6'd0,    0, 0, 4'd0,  E_FETCH_W);
        add(1, OP_LW,  6'd0,    0, 1, 4'd0,  E_FETCH_R);
        add(1, OP_LW,  6'd0,    0, 1, 4'd1,  E_DEC);
        add(1, OP_LW,  6'd0,    0, 1, 4'd2,  E_MEMADR);
        add(1, OP_LW,  6'd0,    0, 0, 4'd3,  E_MEMRD);
        add(0, OP_LW,  6'd0,    0, 0, 4'd0,  E_ZERO);
        // timeout: four idle FETCH cycles, then HALT until reset
        add(1, OP_LW,  6'd0,    0, 0, 4'd0,  E_FETCH_W);
        add(1, OP_LW,  6'd0,    0, 0, 4'd0,  E_FETCH_W);
        add(1, OP_LW,  6'd0,    0, 0, 4'd0,  E_FETCH_W);
        add(1, OP_LW,  6'd0,    0, 0, 4'd0,  E_FETCH_W);
        add(1, OP_LW,  6'd0,    0, 0, 4'd15, E_HALT);
        add(1, OP_LW,  6'd0,    0, 1, 4'd15, E_HALT);
        add(0, OP_LW,  6'd0,    0, 1, 4'd0,  E_ZERO);
        add(1, OP_LW,  6'd0,    0, 1, 4'd0,  E_FETCH_R);

        for (int i = 0; i < tbl.size(); i++) begin
            reset     = tbl[i].rst;
            OpCode    = tbl[i].op;
            Funct     = tbl[i].fn;
            Zero      = tbl[i].z;
            mem_ready = tbl[i].rdy;
            @(negedge clk);
            checks++;
            if (state !== tbl[i].st || observed() !== tbl[i].ctl) begin
                failures++;
                $display("FAIL vec_%0d: state got %0d want %0d, strobes got %b want %b",
                         i, state, tbl[i].st, observed(), tbl[i].ctl);
            end
            @(posedge clk); #1;
        end

        // Latency with mem_ready high, plus the stalled store.
        run_latency("beq",  OP_BEQ, 6'd0,    0, 3);
        run_latency("j",    OP_J,   6'd0,    0, 3);
        run_latency("jal",  OP_JAL, 6'd0,    0, 3);
        run_latency("jr",   OP_R,   FN_JR,   0, 3);
        run_latency("addu", OP_R,   FN_ADDU, 0, 4);
        run_latency("ori",  OP_ORI, 6'd0,    0, 4);
        run_latency("sw",   OP_SW,  6'd0,    0, 4);
        run_latency("lw",   OP_LW,  6'd0,    0, 5);
        run_latency("sw_w3", OP_SW, 6'd0,    3, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
